pipe_stage_skid: RTL

//  Parametrised pipeline-stage register with a valid/ready handshake, 2-entry skid buffering and flush.

---
 rtl/pipe_stage_skid_pkg.sv | 36 +++
 rtl/pipe_stage_skid_if.sv | 18 +
 rtl/pipe_stage_skid_slot.sv | 36 +++
 rtl/pipe_stage_skid.sv | 88 ++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and defaults for the pipeline-stage register slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_stage_skid_pkg;

    // Default widths for the EX->MEM stage this block replaces
    localparam int N_DEF      = 64;
    localparam int CTRL_W_DEF = 4;
    localparam int REG_W_DEF  = 5;

    // Control bit positions; MSB first: memWrite, memRead, memToReg, regWrite
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_REG_WRITE  = 0;

    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic reg_write;
    } ctrl_t;

    // Build a control word from named flags so callers never hard-code bit order
    function automatic ctrl_t make_ctrl(input logic mem_write, input logic mem_read,
                                        input logic mem_to_reg, input logic reg_write);
        logic [CTRL_W_DEF-1:0] v;
        v                  = '0;
        v[CTRL_MEM_WRITE]  = mem_write;
        v[CTRL_MEM_READ]   = mem_read;
        v[CTRL_MEM_TO_REG] = mem_to_reg;
        v[CTRL_REG_WRITE]  = reg_write;
        return ctrl_t'(v);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one pipeline entry (ctrl, rd, alu, wdata).
// Latency: none (wires only).
// Backpressure: ready flows from slave to master; payload valid only with valid.
interface pipe_stage_skid_if import pipe_stage_skid_pkg::*; #(
    parameter int N      = N_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int REG_W  = REG_W_DEF
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rd;
    logic [N-1:0]      alu;
    logic [N-1:0]      wdata;

    modport master (output valid, ctrl, rd, alu, wdata, input ready);
    modport slave  (input valid, ctrl, rd, alu, wdata, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One valid flag plus payload register with load/clear enables.
// Latency: 1 cycle from load to q/vld.
// Backpressure: none; the parent decides when to load or clear.
module pipe_stage_skid_slot import pipe_stage_skid_pkg::*; #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    // Valid flag: clear beats load so a flush can never be overridden
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end
    end

    // Payload only moves on load, keeping the wide register quiet during bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid and flush.
// Latency: 1 cycle empty-to-out; 1 entry/cycle sustained when downstream is ready.
// Backpressure: SKID=1 absorbs one stall cycle with registered ready; SKID=0 passes ready combinationally.
module pipe_stage_skid import pipe_stage_skid_pkg::*; #(
    parameter int N      = N_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    pipe_stage_skid_if.slave  up,
    pipe_stage_skid_if.master dn
);

    localparam int W = CTRL_W + REG_W + 2 * N;

    logic [W-1:0]      in_dat;
    logic [W-1:0]      main_d;
    logic [W-1:0]      main_dat;
    logic              main_v;
    logic              main_load;
    logic              main_clr;
    logic              in_rdy;
    logic              in_fire;
    logic              out_fire;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_dat   = {up.ctrl, up.rd, up.alu, up.wdata};
    assign in_fire  = up.valid & in_rdy;
    assign out_fire = main_v & dn.ready;
    assign up.ready = in_rdy;

    generate
        if (SKID) begin : g_skid
            logic         skid_v;
            logic [W-1:0] skid_dat;
            logic         skid_load;
            logic         skid_clr;

            // Ready depends only on skid occupancy, so there is no in->out combinational path
            assign in_rdy = !skid_v;

            // Main refills when it is empty or draining, preferring the older skid entry.
            // Skid is only ever full while main is full, so in_fire and skid_v never coincide.
            assign main_load = !flush && (!main_v || out_fire) && (skid_v || in_fire);
            assign main_clr  = flush || (out_fire && !skid_v && !in_fire);
            assign main_d    = skid_v ? skid_dat : in_dat;

            // Skid catches the entry accepted while main is stalled
            assign skid_load = !flush && main_v && !dn.ready && in_fire;
            assign skid_clr  = flush || (skid_v && out_fire);

            pipe_stage_skid_slot #(.W(W)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_load),
                .clr   (skid_clr),
                .d     (in_dat),
                .vld   (skid_v),
                .q     (skid_dat)
            );
        end else begin : g_single
            // Single slot: accept whenever the slot is empty or is being drained this cycle
            assign in_rdy    = !main_v | dn.ready;
            assign main_load = !flush && in_fire;
            assign main_clr  = flush || (out_fire && !in_fire);
            assign main_d    = in_dat;
        end
    endgenerate

    pipe_stage_skid_slot #(.W(W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clr   (main_clr),
        .d     (main_d),
        .vld   (main_v),
        .q     (main_dat)
    );

    // Control bits are masked during bubbles so downstream never sees stale writes
    assign {main_ctrl, dn.rd, dn.alu, dn.wdata} = main_dat;
    assign dn.valid = main_v;
    assign dn.ctrl  = main_v ? main_ctrl : '0;

endmodule
